// File: rtl/axu_mem_arbiter.sv
// N-port memory arbiter: registered grant, fixed-priority or round-robin selection,
// optional grant lock for back-to-back transactions from the same requester.
module axu_mem_arbiter #(
   parameter int unsigned NPORTS = 2,
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned RR     = 0,
   localparam int unsigned GW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORTS-1:0]    p_re,
   input  logic [NPORTS-1:0]    p_we,
   input  logic [NPORTS-1:0]    p_lock,
   input  logic [2*NPORTS-1:0]  p_asize,
   input  logic [AW*NPORTS-1:0] p_addr,
   input  logic [DW*NPORTS-1:0] p_wdata,
   output logic [NPORTS-1:0]    p_ready,
   output logic [DW-1:0]        p_rdata,
   output logic                 m_re,
   output logic                 m_we,
   output logic [1:0]           m_asize,
   output logic [AW-1:0]        m_addr,
   output logic [DW-1:0]        m_wdata,
   input  logic                 m_ready,
   input  logic [DW-1:0]        m_rdata,
   output logic [GW-1:0]        grant,
   output logic                 busy
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              locked_q, locked_d;
   logic [GW-1:0]     arb_idx;
   logic [NPORTS-1:0] req;

   assign req = p_re | p_we;

   // Later loop iterations overwrite earlier ones: fixed mode keeps the highest index,
   // round-robin walks the offsets backwards so the first port at/after rr_ptr wins.
   always_comb begin
      arb_idx = '0;
      if (RR != 0) begin
         for (int k = int'(NPORTS) - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr_q) + k) % int'(NPORTS)]) begin
               arb_idx = GW'((int'(rr_ptr_q) + k) % int'(NPORTS));
            end
         end
      end else begin
         for (int i = 0; i < int'(NPORTS); i++) begin
            if (req[i]) arb_idx = GW'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      locked_d = locked_q;
      p_ready  = '0;
      unique case (state_q)
         StIdle: begin
            if (locked_q && req[grant_q]) begin
               state_d = StBusy;
            end else begin
               locked_d = 1'b0;
               if (|req) begin
                  grant_d = arb_idx;
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            // A withdrawn request aborts silently, even if memory completes this cycle.
            if (!req[grant_q]) begin
               state_d  = StIdle;
               locked_d = 1'b0;
            end else if (m_ready) begin
               p_ready[grant_q] = 1'b1;
               state_d          = StIdle;
               locked_d         = p_lock[grant_q];
               if (RR != 0) rr_ptr_d = GW'((int'(grant_q) + 1) % int'(NPORTS));
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         locked_q <= locked_d;
      end
   end

   always_comb begin
      busy    = (state_q == StBusy);
      m_re    = busy & p_re[grant_q];
      m_we    = busy & p_we[grant_q];
      m_asize = p_asize[int'(grant_q)*2 +: 2];
      m_addr  = p_addr[int'(grant_q)*int'(AW) +: AW];
      m_wdata = p_wdata[int'(grant_q)*int'(DW) +: DW];
      p_rdata = m_rdata;
      grant   = grant_q;
   end

endmodule

// File: doc/axu_mem_arbiter.md
Name: axu_mem_arbiter

Overview:
- Parametrised N-port memory access arbiter that merges NPORTS read/write requester ports onto one memory port.
- It replaces the two-port combinational-select converter with a registered grant, selectable fixed-priority or round-robin arbitration, and an optional lock for back-to-back transactions.
- It sits between the CPU fetch/load-store/debug masters and the single memory/bus port.
- Data paths are split into wdata and rdata; there are no tri-states.

Parameters:
- NPORTS, 2: number of requester ports, 2..8.
- AW, 32: address width.
- DW, 32: data width.
- RR, 0: arbitration mode. 0 = fixed priority, where the highest port index wins. 1 = round-robin.

Ports:
- clk  in  1  common clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- p_re  in  NPORTS  per-port read enable.
- p_we  in  NPORTS  per-port write enable.
- p_lock  in  NPORTS  per-port lock request; keeps the grant after completion.
- p_asize  in  2*NPORTS  per-port access size, 2^n bytes; port i uses bits [2i+1:2i].
- p_addr  in  AW*NPORTS  per-port address; port i uses slice i.
- p_wdata  in  DW*NPORTS  per-port write data.
- p_ready  out  NPORTS  per-port completion strobe.
- p_rdata  out  DW  read data, broadcast to all ports; valid only with that port's p_ready.
- m_re  out  1  memory read enable.
- m_we  out  1  memory write enable.
- m_asize  out  2  memory access size.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_ready  in  1  memory completion strobe.
- m_rdata  in  DW  memory read data.
- grant  out  $clog2(NPORTS) (min 1)  index of the currently granted port (debug/perf).
- busy  out  1  high while in BUSY.

Behaviour:
- State machine: IDLE and BUSY. Registers: state, grant, rr_ptr, locked.
- Reset values: state=IDLE, grant=0, rr_ptr=0, locked=0. This gives m_re=0, m_we=0, p_ready=0, busy=0. m_addr, m_asize and m_wdata follow port 0's inputs.
- A request from port i is req[i] = p_re[i] | p_we[i].
- IDLE with any req set:
  - RR=0: grant <= highest i with req[i].
  - RR=1: grant <= first requesting i scanning rr_ptr, rr_ptr+1, ... modulo NPORTS.
  - state <= BUSY.
- IDLE with no req: hold. m_ready is ignored in IDLE.
- IDLE with locked=1: grant is held and not re-arbitrated. Only port grant may start a transaction; other ports wait.
- Latency: a request sampled at edge k drives m_re/m_we from cycle k+1. Minimum total latency is 2 cycles: a request at edge k with m_ready=1 in cycle k+1 completes at edge k+2.
- In BUSY, the memory outputs are muxed from port grant: m_re=p_re[grant], m_we=p_we[grant], plus that port's addr, asize and wdata.
  - m_re and m_we are both forwarded if both are set; no precedence is applied.
  - Outside BUSY, m_re=m_we=0.
- Completion: in BUSY with m_ready=1:
  - p_ready[grant]=1 combinationally in that cycle; all other p_ready bits stay 0.
  - p_rdata=m_rdata combinationally (always passed through).
  - At the next edge: state <= IDLE, locked <= p_lock[grant], and rr_ptr <= (grant+1) mod NPORTS when RR=1.
- IDLE is a one-cycle arbitration bubble between transactions.
- Requester rule: a port holds re/we, addr, asize and wdata stable until its p_ready. It deasserts re/we in the cycle after p_ready, unless it issues a new request.
- Withdrawal: in BUSY, if req[grant]=0, the transaction aborts. No p_ready is issued, state <= IDLE, locked <= 0. An m_ready in that cycle is ignored.
- Lock release: in IDLE with locked=1 and req[grant]=0, locked <= 0 and normal arbitration runs in the same cycle.
- Simultaneous events: rst overrides everything. Reset mid-transaction returns to IDLE at that edge and issues no p_ready. m_re/m_we are 0 in the cycle after the reset edge.
- NPORTS=1: grant is constant 0 and the arbiter degenerates to a registered pass-through with a one-cycle bubble.
- Assertions for the bench:
  - p_ready is onehot0.
  - p_ready is never set outside BUSY.
  - grant < NPORTS.

Test Plan:
- NPORTS=2, RR=0; ports 0 and 1 both read at the same edge, addr0=0x100, addr1=0x200; memory ready after 1 cycle → port 1 served first (m_addr=0x200, p_ready=2'b10). Then after one IDLE cycle port 0 is served (m_addr=0x100, p_ready=2'b01), with p_rdata matching the m_rdata of each.
- NPORTS=4, RR=1; all four ports request continuously → grant sequence 0,1,2,3,0. Each transaction completes with p_ready onehot on the granted port only.
- Port 1 writes asize=2, addr=0x40, wdata=0xDEADBEEF while port 0 is idle → m_we=1, m_addr=0x40, m_wdata=0xDEADBEEF, m_asize=2 from the cycle after the request. p_ready[1]=1 in the cycle m_ready=1.
- NPORTS=2, RR=0; port 0 with p_lock=1 issues two back-to-back reads while port 1 is requesting → both port-0 reads are served before port 1 is granted. Port 1 is granted only after port 0 drops its request.
- rst asserted while BUSY with m_ready=0 → next cycle state=IDLE, m_re=m_we=0, busy=0, no p_ready ever pulsed, rr_ptr=0, grant=0.
- Granted port 1 drops re while BUSY and m_ready=1 in the same cycle → no p_ready, state returns to IDLE, the pending port 0 is granted next.
